// File: rtl/stopwatch_bcd_pkg.sv
// stopwatch_bcd_pkg: shared FSM encodings, BCD limits and 7-segment patterns for the stopwatch
package stopwatch_bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = SEG_0;
      4'd1: seg_of = SEG_1;
      4'd2: seg_of = SEG_2;
      4'd3: seg_of = SEG_3;
      4'd4: seg_of = SEG_4;
      4'd5: seg_of = SEG_5;
      4'd6: seg_of = SEG_6;
      4'd7: seg_of = SEG_7;
      4'd8: seg_of = SEG_8;
      4'd9: seg_of = SEG_9;
      default: seg_of = SEG_OFF;
    endcase
  endfunction
endpackage

// File: rtl/stopwatch_bcd_bcd_digit.sv
// bcd_digit: one BCD counter digit with clear, increment and carry-out at a programmable maximum
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] max_val,
  output logic [3:0] digit,
  output logic       carry
);
  assign carry = inc & (digit >= max_val);
  // digit register: clear wins, otherwise wrap to 0 on carry or step by one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit <= '0;
    else if (clr) digit <= '0;
    else if (inc) digit <= carry ? 4'd0 : digit + 4'd1;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS BCD stopwatch driven by a synchronized 1 Hz wave; STOPWATCH_SEG_EN adds a scanned 7-segment output
module stopwatch_bcd
  import stopwatch_bcd_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_MIN_TENS = 5,
  parameter int SCAN_DIV     = 100_000
) (
  input  logic       i_clk_100MHz,
  input  logic       i_rst_n,
  input  logic       i_clk_1Hz,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clear,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic       o_running,
`ifdef STOPWATCH_SEG_EN
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
`endif
  output logic       o_rollover
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;
  logic                   tick;
  logic                   inc;
  logic [3:0]             c;
  state_t                 state;
  state_t                 nxt;
  // shift the async 1 Hz wave through the synchronizer, plus one delay flop for edge detection
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
    if (!i_rst_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_clk_1Hz};
      dly  <= sync[SYNC_STAGES-1];
    end
  assign tick = sync[SYNC_STAGES-1] & ~dly;
  assign nxt  = i_clear ? IDLE : i_stop ? (state == RUN ? PAUSE : state) : i_start ? RUN : state;
  assign inc  = tick & (state == RUN) & ~i_clear;
  // control FSM with registered running flag
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= IDLE;
      o_running <= 1'b0;
    end else begin
      state     <= nxt;
      o_running <= nxt == RUN;
    end
  bcd_digit u_sec_ones (.clk(i_clk_100MHz), .rst_n(i_rst_n), .clr(i_clear), .inc(inc),  .max_val(ONES_MAX), .digit(o_sec_ones), .carry(c[0]));
  bcd_digit u_sec_tens (.clk(i_clk_100MHz), .rst_n(i_rst_n), .clr(i_clear), .inc(c[0]), .max_val(TENS_MAX), .digit(o_sec_tens), .carry(c[1]));
  bcd_digit u_min_ones (.clk(i_clk_100MHz), .rst_n(i_rst_n), .clr(i_clear), .inc(c[1]), .max_val(ONES_MAX), .digit(o_min_ones), .carry(c[2]));
  bcd_digit u_min_tens (.clk(i_clk_100MHz), .rst_n(i_rst_n), .clr(i_clear), .inc(c[2]), .max_val(4'(MAX_MIN_TENS)), .digit(o_min_tens), .carry(c[3]));
  // carry out of the top digit marks the wrap to 00:00, flagged in the same cycle the zeros appear
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
    if (!i_rst_n) o_rollover <= 1'b0;
    else o_rollover <= c[3];
`ifdef STOPWATCH_SEG_EN
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic [3:0]    sel;
  assign nidx = cnt == CW'(SCAN_DIV - 1) ? idx + 2'd1 : idx;
  assign sel  = nidx == 2'd0 ? o_sec_ones : nidx == 2'd1 ? o_sec_tens : nidx == 2'd2 ? o_min_ones : o_min_tens;
  // scan timer; anode and segments are both loaded from the next index so they switch together
  always_ff @(posedge i_clk_100MHz or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt   <= '0;
      idx   <= 2'd0;
      o_an  <= 4'b1110;
      o_seg <= SEG_0;
    end else begin
      cnt   <= cnt == CW'(SCAN_DIV - 1) ? '0 : cnt + CW'(1);
      idx   <= nidx;
      o_an  <= ~(4'b0001 << nidx);
      o_seg <= seg_of(sel);
    end
`endif
endmodule
